// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the unified-memory IF/LS arbiter.
package arb_type;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IF   = 2'd1,
      ARB_LS   = 2'd2
   } arb_state_e;

   // Widest supported byte mask; users slice to DATA_W/8 bits.
   localparam logic [31:0] MASK_FULL = {32{1'b1}};

endpackage

// File: rtl/imem_dmem_arbiter_wdt.sv
// Access watchdog for imem_dmem_arbiter; only built when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_wdt #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt_r;

   // Wait-cycle counter: cleared while idle, counts cycles spent without mem_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/imem_dmem_arbiter.sv
// Fixed-priority (LS > IF) arbiter for a single-port unified memory.
// Optional access timeout enabled by defining ARB_TIMEOUT_EN.
import arb_type::*;

module imem_dmem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_vld,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_bmask,
   output logic                ls_gnt,
   output logic                ls_vld,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_bmask,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic                err
);

   localparam int BM_W = DATA_W / 8;

   arb_state_e        state_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [BM_W-1:0]   mem_bmask_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] ls_rdata_r;
   logic              if_vld_r;
   logic              ls_vld_r;
   logic              err_r;
   logic              idle_s;
   logic              busy_s;
   logic              timeout_s;

   assign idle_s = (state_r == ARB_IDLE);
   assign busy_s = !idle_s;

   // Grants are combinational so a request is accepted in the cycle it is seen idle.
   assign ls_gnt = idle_s && ls_req && !rst;
   assign if_gnt = idle_s && if_req && !ls_req && !rst;

`ifdef ARB_TIMEOUT_EN
   logic expired_s;

   arb_wdt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .clr     (idle_s),
      .en      (busy_s && !mem_ready),
      .expired (expired_s)
   );

   // A ready arriving on the limit cycle still wins over the abort.
   assign timeout_s = busy_s && !mem_ready && expired_s;
`else
   logic unused_timeout_s;

   assign unused_timeout_s = (TIMEOUT > 32'sd0);
   assign timeout_s        = 1'b0;
`endif

   // Arbiter FSM with registered memory-side and completion outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ARB_IDLE;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         mem_bmask_r <= '0;
         if_rdata_r  <= '0;
         ls_rdata_r  <= '0;
         if_vld_r    <= 1'b0;
         ls_vld_r    <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         if_vld_r <= 1'b0;
         ls_vld_r <= 1'b0;
         err_r    <= 1'b0;
         case (state_r)
            ARB_IDLE: begin
               if (ls_req) begin
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= ls_we;
                  mem_addr_r  <= ls_addr;
                  mem_wdata_r <= ls_wdata;
                  mem_bmask_r <= ls_bmask;
                  state_r     <= ARB_LS;
               end else if (if_req) begin
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= 1'b0;
                  mem_addr_r  <= if_addr;
                  mem_wdata_r <= '0;
                  mem_bmask_r <= MASK_FULL[BM_W-1:0];
                  state_r     <= ARB_IF;
               end else begin
                  state_r <= ARB_IDLE;
               end
            end
            ARB_IF: begin
               if (mem_ready) begin
                  if_rdata_r <= mem_rdata;
                  if_vld_r   <= 1'b1;
                  mem_req_r  <= 1'b0;
                  state_r    <= ARB_IDLE;
               end else if (timeout_s) begin
                  if_rdata_r <= '0;
                  if_vld_r   <= 1'b1;
                  err_r      <= 1'b1;
                  mem_req_r  <= 1'b0;
                  state_r    <= ARB_IDLE;
               end else begin
                  state_r <= ARB_IF;
               end
            end
            ARB_LS: begin
               if (mem_ready) begin
                  if (!mem_we_r) begin
                     ls_rdata_r <= mem_rdata;
                  end else begin
                     ls_rdata_r <= ls_rdata_r;
                  end
                  ls_vld_r  <= 1'b1;
                  mem_req_r <= 1'b0;
                  state_r   <= ARB_IDLE;
               end else if (timeout_s) begin
                  ls_rdata_r <= '0;
                  ls_vld_r   <= 1'b1;
                  err_r      <= 1'b1;
                  mem_req_r  <= 1'b0;
                  state_r    <= ARB_IDLE;
               end else begin
                  state_r <= ARB_LS;
               end
            end
            default: begin
               mem_req_r <= 1'b0;
               state_r   <= ARB_IDLE;
            end
         endcase
      end
   end

   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign mem_bmask = mem_bmask_r;
   assign if_rdata  = if_rdata_r;
   assign ls_rdata  = ls_rdata_r;
   assign if_vld    = if_vld_r;
   assign ls_vld    = ls_vld_r;
   assign err       = err_r;
   assign busy      = busy_s;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter; covers the timeout path when ARB_TIMEOUT_EN is defined.
module tb_imem_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, ls_req, ls_we, mem_ready;
   logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
   logic [3:0]  ls_bmask;
   logic        if_gnt, if_vld, ls_gnt, ls_vld, mem_req, mem_we, busy, err;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_bmask;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t if_q[$];
   exp_t ls_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   g;

   imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_vld(if_vld), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_bmask(ls_bmask),
      .ls_gnt(ls_gnt), .ls_vld(ls_vld), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_bmask(mem_bmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives mem_ready after w wait cycles; checks the request is held meanwhile.
   task automatic serve(input int w, input logic [31:0] d, input logic [31:0] addr);
      for (int i = 0; i <= w; i++) begin
         mem_ready = (i == w);
         mem_rdata = (i == w) ? d : 32'h0;
         #1;
         check("mem_req_hold", mem_req, 1'b1);
         check("mem_addr_hold", mem_addr, addr);
         check("busy_in_access", busy, 1'b1);
         tick();
      end
      mem_ready = 1'b0;
   endtask

   // Scoreboard monitor: pops an expectation on every completion pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (if_gnt && ls_gnt) check("gnt_exclusive", 1'b1, 1'b0);
            if (err && !if_vld && !ls_vld) check("err_without_vld", 1'b1, 1'b0);
            if (if_vld) begin
               if (if_q.size() == 0) begin
                  check("if_vld_unexpected", 1'b1, 1'b0);
               end else begin
                  e = if_q.pop_front();
                  check("if_rdata", if_rdata, e.data);
                  check("if_err", err, e.err);
                  check("if_vld_cycle", cyc, e.cyc);
               end
            end
            if (ls_vld) begin
               if (ls_q.size() == 0) begin
                  check("ls_vld_unexpected", 1'b1, 1'b0);
               end else begin
                  e = ls_q.pop_front();
                  check("ls_rdata", ls_rdata, e.data);
                  check("ls_err", err, e.err);
                  check("ls_vld_cycle", cyc, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_ready = 1'b0;
      if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_bmask = 4'h0; mem_rdata = 32'h0;
      tick(); tick();
      check("reset_ctrl", {mem_req, mem_we, busy, if_gnt, ls_gnt, if_vld, ls_vld, err}, 8'h00);
      check("reset_mem", {mem_addr, mem_wdata}, 64'h0);
      check("reset_rdata", {if_rdata, ls_rdata}, 64'h0);
      check("reset_bmask", mem_bmask, 4'h0);
      rst = 1'b0;
      tick();

      // Zero-wait fetch.
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      check("fetch_gnt", {if_gnt, ls_gnt}, 2'b10);
      if_q.push_back('{32'h0050_0093, 1'b0, cyc + 2});
      tick();
      if_req = 1'b0;
      check("fetch_mem_we", mem_we, 1'b0);
      check("fetch_mem_bmask", mem_bmask, 4'hF);
      serve(0, 32'h0050_0093, 32'h100);
      check("fetch_vld", if_vld, 1'b1);
      check("fetch_idle", {busy, mem_req}, 2'b00);
      tick();

      // Load with three wait states.
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h3000; ls_bmask = 4'hF;
      #1;
      check("load_gnt", ls_gnt, 1'b1);
      ls_q.push_back('{32'h1234_5678, 1'b0, cyc + 5});
      tick();
      ls_req = 1'b0;
      serve(3, 32'h1234_5678, 32'h3000);
      check("load_vld", {ls_vld, busy}, 2'b10);
      tick();

      // Simultaneous store and fetch: store first, fetch granted alongside ls_vld.
      if_req = 1'b1; if_addr = 32'h200;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2004; ls_wdata = 32'hDEAD_BEEF; ls_bmask = 4'b0011;
      #1;
      check("prio_gnt", {ls_gnt, if_gnt}, 2'b10);
      ls_q.push_back('{32'h1234_5678, 1'b0, cyc + 2});
      tick();
      ls_req = 1'b0;
      check("store_mem_fields", {mem_we, mem_bmask, mem_wdata}, {1'b1, 4'b0011, 32'hDEAD_BEEF});
      check("busy_no_gnt", if_gnt, 1'b0);
      serve(0, 32'hCAFE_F00D, 32'h2004);
      check("gnt_with_vld", {ls_vld, if_gnt}, 2'b11);
      if_q.push_back('{32'h0000_0013, 1'b0, cyc + 2});
      tick();
      if_req = 1'b0;
      check("fetch2_mem_fields", {mem_we, mem_bmask}, {1'b0, 4'hF});
      serve(0, 32'h0000_0013, 32'h200);
      tick();

      // Continuous fetch stream with memory always ready.
      if_req = 1'b1; mem_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if_addr = 32'h400 + 32'(4 * k);
         mem_rdata = 32'hA000_0000 + 32'(k);
         #1;
         check("stream_gnt", if_gnt, 1'b1);
         if_q.push_back('{32'hA000_0000 + 32'(k), 1'b0, cyc + 2});
         tick();
         if (k == 3) if_req = 1'b0;
         check("stream_busy_gnt", {busy, if_gnt}, 2'b10);
         tick();
      end
      mem_ready = 1'b0;
      tick();

`ifdef ARB_TIMEOUT_EN
      // Abort after 16 silent wait cycles.
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h6000;
      #1;
      check("to_gnt", ls_gnt, 1'b1);
      ls_q.push_back('{32'h0, 1'b1, cyc + 17});
      tick();
      ls_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("to_wait_req", mem_req, 1'b1);
         tick();
      end
      check("to_abort", {ls_vld, err, mem_req, busy}, 4'b1100);
      tick();
      // Ready on the limit cycle is a success.
      ls_req = 1'b1;
      #1;
      ls_q.push_back('{32'h7777_8888, 1'b0, cyc + 17});
      tick();
      ls_req = 1'b0;
      serve(15, 32'h7777_8888, 32'h6000);
      check("to_limit_ok", {ls_vld, err}, 2'b10);
      tick();
`else
      // Without the watchdog a long wait simply completes.
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h6000;
      #1;
      ls_q.push_back('{32'h0BAD_F00D, 1'b0, cyc + 22});
      tick();
      ls_req = 1'b0;
      serve(20, 32'h0BAD_F00D, 32'h6000);
      check("long_wait_vld", {ls_vld, err}, 2'b10);
      tick();
`endif

      // Reset in the middle of a load that never completes.
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h5000;
      #1;
      check("rst_mid_gnt", ls_gnt, 1'b1);
      tick();
      ls_req = 1'b0;
      tick(); tick();
      check("rst_mid_active", mem_req, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_mid_async", {mem_req, busy}, 2'b00);
      tick();
      rst = 1'b0;
      check("rst_mid_ctrl", {mem_req, mem_we, busy, if_gnt, ls_gnt, if_vld, ls_vld, err}, 8'h00);
      check("rst_mid_data", {mem_addr, ls_rdata}, 64'h0);
      tick(); tick(); tick();

      check("if_q_drained", if_q.size(), 0);
      check("ls_q_drained", ls_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and load/store (LS) in the RV32I core.
- Sequences each access with a req/gnt handshake toward the requesters and a req/ready handshake toward memory.
- Returns read data with a one-cycle valid pulse and exposes a busy flag the core uses to hold the PC.
- Sits between PC/fetch logic, LSU (consumer of wr_en/bmask/ld_sel from decode) and memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; bmask width is DATA_W/8.
- TIMEOUT, 16, max wait cycles for mem_ready; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle accept pulse.
- if_vld  out  1  one-cycle fetch-data-valid pulse.
- if_rdata  out  DATA_W  fetched instruction; stable until next if_vld.
- ls_req  in  1  data request; held until ls_gnt.
- ls_we  in  1  1 = store.
- ls_addr  in  ADDR_W  data address.
- ls_wdata  in  DATA_W  store data.
- ls_bmask  in  DATA_W/8  store byte mask.
- ls_gnt  out  1  one-cycle accept pulse.
- ls_vld  out  1  one-cycle completion pulse, loads and stores.
- ls_rdata  out  DATA_W  load data; stable until next ls_vld.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_bmask  out  DATA_W/8  memory byte mask.
- mem_ready  in  1  memory completion; mem_rdata valid the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  1 when state != IDLE.
- err  out  1  one-cycle pulse with vld on timeout abort.

Behaviour:
- Reset (async): state=IDLE; all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_bmask, if_rdata, ls_rdata, gnt/vld/err, busy).
- Reset mid-access aborts the transaction: no vld, mem_req drops immediately. Memory must tolerate a dropped request.
- States: IDLE, ACC_IF, ACC_LS.
- IDLE:
  - Fixed priority LS > IF.
  - ls_req: ls_gnt=1 (combinational); latch we/addr/wdata/bmask into mem_* regs; next=ACC_LS.
  - Else if_req: if_gnt=1; mem_we=0, mem_bmask=all-ones, mem_addr=if_addr; next=ACC_IF.
- ACC_x:
  - mem_req=1 and mem_* stable every cycle until mem_ready.
  - On mem_ready: capture mem_rdata into x_rdata (loads/fetch only; stores leave ls_rdata unchanged); next=IDLE.
  - x_vld pulses in the first IDLE cycle after mem_ready.
- Latency: gnt cycle N; mem_req high from N+1; mem_ready at N+1+W (W = wait states ≥ 0); vld at N+2+W. Minimum 2 cycles.
- IDLE may grant a new request in the same cycle as a vld. Back-to-back peak is one access per 2 cycles.
- Simultaneous if_req and ls_req in IDLE: LS wins. IF stays pending and is granted on the next IDLE cycle.
- Requests arriving while busy are ignored (no gnt) until IDLE.
- Addresses and masks pass through unmodified. Alignment and byte lane shifting belong to the LSU.
- busy is registered-state derived with no combinational path from inputs.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to ACC_x and increments each cycle without mem_ready.
  - At count == TIMEOUT-1 without mem_ready: abort, drop mem_req, next=IDLE.
  - x_vld and err pulse together next cycle; x_rdata loaded with 0.
  - mem_ready in the same cycle as the limit counts as success (no err).
- Undefined: no counter, err tied 0, waits indefinitely.

Decomposition:
- Package arb_type:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_IF, ARB_LS}.
  - Localparam MASK_FULL.
- Sub-module arb_wdt (timeout counter with clr/en/expired), instantiated only under ARB_TIMEOUT_EN. Otherwise a single module.

Test Plan:
- Reset mid ACC_LS with mem_ready never asserted -> next cycle mem_req=0, busy=0, no ls_vld, all outputs 0.
- if_req, if_addr=0x100, mem_ready high first cycle, mem_rdata=0x00500093 -> if_gnt cycle 0, mem_req cycle 1, if_vld and if_rdata=0x00500093 cycle 2, mem_bmask=4'hF, mem_we=0.
- if_req and ls_req (we=1, addr=0x2004, wdata=0xDEADBEEF, bmask=4'b0011) same cycle -> ls_gnt first with mem_* matching inputs; ls_vld; if_gnt in the same cycle as ls_vld; ls_rdata unchanged.
- Load with 3 wait states, mem_rdata=0x12345678 -> mem_addr/mem_req stable 4 cycles; ls_vld at gnt+5, ls_rdata=0x12345678, busy high gnt+1..gnt+4.
- Continuous if_req, 4 requests, mem_ready always 1 -> if_vld every 2 cycles, no lost or duplicated grants.
- ARB_TIMEOUT_EN, TIMEOUT=16, mem_ready held 0 -> abort after 16 wait cycles; ls_vld=err=1 next cycle, ls_rdata=0. Repeat with mem_ready on the 16th cycle -> err=0.
